// File: rtl/run_detect_pkg.sv
// Shared encodings for the run-length pattern detector.
// Mode codes select which run shape lights the LED; state codes track the
// polarity of the run currently being counted.
package run_detect_pkg;

  // Pattern selection, loaded from the mode input on save
  typedef enum logic [1:0] {
    MODE_ONES       = 2'b00,
    MODE_ZEROS      = 2'b01,
    MODE_ONES_ZEROS = 2'b10,
    MODE_EITHER     = 2'b11
  } mode_e;

  // DISARMED while the threshold is zero; otherwise the polarity of the last sample
  typedef enum logic [1:0] {
    DISARMED  = 2'b00,
    RUN_ONES  = 2'b01,
    RUN_ZEROS = 2'b10
  } state_e;

endpackage : run_detect_pkg

// File: rtl/sat_counter.sv
// Purpose: up-counter that sticks at all-ones; clr restarts it (at 1 if inc is also set).
// Latency: q reflects clr/inc one clock after they are presented.
// Backpressure: none; inc is honoured every cycle until saturation.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = {W{1'b1}};
  localparam logic [W-1:0] Q_ONE = {{(W-1){1'b0}}, 1'b1};

  // Restart on clr (counting the current event if inc), otherwise count up and hold at max
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? Q_ONE : '0;
    end else if (inc && (q != Q_MAX)) begin
      q <= q + Q_ONE;
    end
  end

endmodule : sat_counter

// File: rtl/run_pattern_detector.sv
// Purpose: serial run-length detector (N ones, N zeros, N ones then N zeros, or either run) driving an LED.
// Latency: led_out/hit rise on the edge that registers the Nth qualifying sample; led_out drops on the breaking sample.
// Backpressure: none; w is sampled every rising edge. Optional hit counter built when RPD_HIT_COUNT_EN is defined.
module run_pattern_detector
  import run_detect_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             save,
  input  logic [CNT_W-1:0] n,
  input  logic [1:0]       mode,
  input  logic             w,
  output logic             led_out,
  output logic             hit,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state;
  mode_e            mode_reg;
  logic [CNT_W-1:0] n_reg;
  logic             ones_ok;

  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] zeros_cnt;
  logic [CNT_W-1:0] ones_nxt;
  logic [CNT_W-1:0] zeros_nxt;
  logic             ones_clr;
  logic             ones_inc;
  logic             zeros_clr;
  logic             zeros_inc;
  logic             ones_ok_nxt;
  logic             match;
  logic             led_nxt;
  logic             hit_nxt;
  logic             armed;
  logic             n_nz;

  assign armed = (state != DISARMED);
  assign n_nz  = (n != '0);

  // Counter controls: save restarts both runs from the current bit, a normal sample
  // extends the matching run and clears the other, and a disarmed detector holds zero
  always_comb begin
    ones_clr  = 1'b1;
    ones_inc  = 1'b0;
    zeros_clr = 1'b1;
    zeros_inc = 1'b0;
    if (save) begin
      ones_inc  = n_nz & w;
      zeros_inc = n_nz & ~w;
    end else if (armed) begin
      ones_clr  = ~w;
      ones_inc  = w;
      zeros_clr = w;
      zeros_inc = ~w;
    end
  end

  sat_counter #(.W(CNT_W)) u_ones_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ones_clr),
    .inc (ones_inc),
    .q   (ones_cnt)
  );

  sat_counter #(.W(CNT_W)) u_zeros_cnt (
    .clk (clk),
    .rst (rst),
    .clr (zeros_clr),
    .inc (zeros_inc),
    .q   (zeros_cnt)
  );

  // Next-state run lengths, so the compare sees the sample being registered this edge
  always_comb begin
    ones_nxt  = ones_cnt;
    zeros_nxt = zeros_cnt;
    if (ones_clr) begin
      ones_nxt = ones_inc ? CNT_ONE : '0;
    end else if (ones_inc && (ones_cnt != CNT_MAX)) begin
      ones_nxt = ones_cnt + CNT_ONE;
    end
    if (zeros_clr) begin
      zeros_nxt = zeros_inc ? CNT_ONE : '0;
    end else if (zeros_inc && (zeros_cnt != CNT_MAX)) begin
      zeros_nxt = zeros_cnt + CNT_ONE;
    end
  end

  // ones_ok remembers whether the ones run that just ended was long enough; judged with the pre-clear count
  always_comb begin
    ones_ok_nxt = ones_ok;
    if (save || !armed) begin
      ones_ok_nxt = 1'b0;
    end else if ((state == RUN_ONES) && !w) begin
      ones_ok_nxt = (ones_cnt >= n_reg);
    end else if ((state == RUN_ZEROS) && w) begin
      ones_ok_nxt = 1'b0;
    end
  end

  // Pattern compare on next-state counts; unsigned >= keeps the LED lit through saturation
  always_comb begin
    match = 1'b0;
    case (mode_reg)
      MODE_ONES:       match = (ones_nxt >= n_reg);
      MODE_ZEROS:      match = (zeros_nxt >= n_reg);
      MODE_ONES_ZEROS: match = ones_ok_nxt && (zeros_nxt >= n_reg);
      MODE_EITHER:     match = (ones_nxt >= n_reg) || (zeros_nxt >= n_reg);
      default:         match = 1'b0;
    endcase
    led_nxt = !save && armed && match;
    hit_nxt = led_nxt && !led_out;
  end

  // Control FSM with configuration registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DISARMED;
      n_reg    <= '0;
      mode_reg <= MODE_ONES;
      ones_ok  <= 1'b0;
      led_out  <= 1'b0;
      hit      <= 1'b0;
    end else begin
      ones_ok <= ones_ok_nxt;
      led_out <= led_nxt;
      hit     <= hit_nxt;
      if (save) begin
        n_reg    <= n;
        mode_reg <= mode_e'(mode);
        state    <= n_nz ? (w ? RUN_ONES : RUN_ZEROS) : DISARMED;
      end else if (armed) begin
        state <= w ? RUN_ONES : RUN_ZEROS;
      end
    end
  end

`ifdef RPD_HIT_COUNT_EN
  // Hit counter lives across saves; only reset clears it
  sat_counter #(.W(HIT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (hit_nxt),
    .q   (hit_cnt)
  );
`else
  assign hit_cnt = '0;
`endif

endmodule : run_pattern_detector

// File: tb/tb_run_pattern_detector.sv
// Bench for run_pattern_detector: directed scenarios followed by a randomized stream,
// all checked against a history-based model of the run rules.
module tb_run_pattern_detector;

  localparam int CNT_W   = 4;
  localparam int HIT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int HIT_MAX = (1 << HIT_W) - 1;
`ifdef RPD_HIT_COUNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic             clk  = 1'b0;
  logic             rst  = 1'b0;
  logic             save = 1'b0;
  logic [CNT_W-1:0] n    = '0;
  logic [1:0]       mode = '0;
  logic             w    = 1'b0;
  logic             led_out;
  logic             hit;
  logic [HIT_W-1:0] hit_cnt;

  run_pattern_detector #(.CNT_W(CNT_W), .HIT_W(HIT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .save    (save),
    .n       (n),
    .mode    (mode),
    .w       (w),
    .led_out (led_out),
    .hit     (hit),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: samples seen since the last save, plus the loaded configuration
  bit hist[$];
  int m_n    = 0;
  int m_mode = 0;
  bit m_led  = 1'b0;
  bit m_hit  = 1'b0;
  int m_hcnt = 0;
  int dut_hits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Length of the trailing run and of the run just before it, read from the history
  function automatic bit model_match();
    int  len_cur = 0;
    int  len_prev = 0;
    int  i;
    bit  last;
    if (m_n == 0 || hist.size() == 0) return 1'b0;
    i = hist.size() - 1;
    last = hist[i];
    while (i >= 0 && hist[i] == last) begin len_cur++; i--; end
    while (i >= 0 && hist[i] != last) begin len_prev++; i--; end
    if (len_cur > CNT_MAX) len_cur = CNT_MAX;
    if (len_prev > CNT_MAX) len_prev = CNT_MAX;
    case (m_mode)
      0:       return last && (len_cur >= m_n);
      1:       return !last && (len_cur >= m_n);
      2:       return !last && (len_prev >= m_n) && (len_cur >= m_n);
      default: return len_cur >= m_n;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    m_n = 0; m_mode = 0; m_led = 1'b0; m_hit = 1'b0; m_hcnt = 0;
  endtask

  // One clock: drive on the falling edge, check just after the rising edge
  task automatic step(input bit s, input int nv, input int mv, input bit wv);
    bit prev;
    @(negedge clk);
    save = s; n = CNT_W'(nv); mode = 2'(mv); w = wv;
    @(posedge clk);
    #1;
    prev = m_led;
    if (s) begin
      hist.delete();
      m_n = nv; m_mode = mv;
      if (nv != 0) hist.push_back(wv);
      m_led = 1'b0;
    end else begin
      if (m_n != 0) hist.push_back(wv);
      m_led = model_match();
    end
    m_hit = m_led && !prev;
    if (m_hit && HIT_EN && m_hcnt < HIT_MAX) m_hcnt++;
    if (hit === 1'b1) dut_hits++;
    check("led_out", led_out, m_led);
    check("hit", hit, m_hit);
    check("hit_cnt", hit_cnt, m_hcnt);
  endtask

  initial begin
    int r;
    bit wr;
    // Reset values
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", led_out, 0);
    check("rst_hit", hit, 0);
    check("rst_hitcnt", hit_cnt, 0);
    check("rst_ones", dut.ones_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: never saved, toggling input with a nonzero n on the pins stays dark
    for (int i = 0; i < 20; i++) step(1'b0, 3, 3, i[0]);
    check("t1_hits", dut_hits, 0);

    // 2: six ones
    dut_hits = 0;
    step(1'b1, 6, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 0, 1'b1);
      check("t2_led", led_out, (i >= 5) ? 1 : 0);
    end
    step(1'b0, 0, 0, 1'b0);
    check("t2_fall", led_out, 0);
    check("t2_hits", dut_hits, 1);

    // 3: three ones then three zeros, and a short ones run that must not match
    step(1'b1, 3, 2, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, (i < 3));
    check("t3_match", led_out, 1);
    step(1'b1, 3, 2, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, (i < 2));
    check("t3_nomatch", led_out, 0);

    // 4: saturation with n at the counter maximum
    dut_hits = 0;
    step(1'b1, 15, 1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 0, 0, 1'b0);
      check("t4_led", led_out, (i >= 14) ? 1 : 0);
    end
    check("t4_sat", dut.zeros_cnt, CNT_MAX);
    check("t4_hits", dut_hits, 1);

    // 5: either-run mode gives one hit per run, then a mid-run save restarts at 1
    step(1'b1, 2, 3, 1'b0);
    dut_hits = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, (i < 2 || i >= 4));
    check("t5_hits", dut_hits, 3);
    step(1'b1, 4, 3, 1'b1);
    check("t5_save_led", led_out, 0);
    check("t5_restart", dut.ones_cnt, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b1);

    // 6: five hits against a 2-bit hit counter, then async reset mid-run
    step(1'b1, 1, 0, 1'b0);
    dut_hits = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, (i % 2 == 0));
    check("t6_hits", dut_hits, 5);
    check("t6_hitcnt", hit_cnt, HIT_EN ? 3 : 0);
    step(1'b1, 2, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    check("t6_pre_led", led_out, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_arst_led", led_out, 0);
    check("t6_arst_hit", hit, 0);
    check("t6_arst_cnt", hit_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 0, 0, 1'b1);

    // Random: run-biased stream with occasional saves of random n/mode
    wr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) wr = ~wr;
      if (r < 5) step(1'b1, $urandom_range(0, 6), $urandom_range(0, 3), wr);
      else if (r < 6) step(1'b1, $urandom_range(0, CNT_MAX), $urandom_range(0, 3), wr);
      else step(1'b0, $urandom_range(0, CNT_MAX), $urandom_range(0, 3), wr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_run_pattern_detector
